// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result, NZCV flags and bit-serial shifts.
// One operation is in flight at a time; shifts advance one bit position per cycle.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_r, shifted;
    logic               alu_c, alu_v, shift_out, legal, is_shift;
    logic [SHAMT_W-1:0] amt;

    always_comb begin
        sum      = {1'b0, operand1} + {1'b0, operand2};
        diff     = {1'b0, operand1} - {1'b0, operand2};
        amt      = operand2[SHAMT_W-1:0];
        legal    = (opcode >= OP_ADD) && (opcode <= OP_ASR);
        is_shift = (opcode == OP_LSL) || (opcode == OP_LSR) || (opcode == OP_ASR);
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                        (sum[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = ~diff[WIDTH];
                alu_v = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                        (diff[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_AND: alu_r = operand1 & operand2;
            OP_OR:  alu_r = operand1 | operand2;
            OP_XOR: alu_r = operand1 ^ operand2;
            OP_NOT: alu_r = ~operand1;
            // A zero-length shift completes immediately with the operand unchanged
            OP_LSL, OP_LSR, OP_ASR: alu_r = operand1;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        shifted   = {result_q[WIDTH-2:0], 1'b0};
        shift_out = result_q[WIDTH-1];
        case (op_q)
            OP_LSR: begin
                shifted   = {1'b0, result_q[WIDTH-1:1]};
                shift_out = result_q[0];
            end
            OP_ASR: begin
                shifted   = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                shift_out = result_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d     = opcode;
                    result_d = alu_r;
                    err_d    = ~legal;
                    flags_d  = legal ? {alu_r[WIDTH-1], (alu_r == '0), alu_c, alu_v}
                                     : 4'b0100;
                    cnt_d    = amt;
                    state_d  = (is_shift && (amt != '0)) ? SHIFT : DONE;
                end
            end
            // The working value lives in result_q; N/Z are only meaningful after the last step
            SHIFT: begin
                result_d = shifted;
                flags_d  = {shifted[WIDTH-1], (shifted == '0), shift_out, 1'b0};
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU: WIDTH-bit datapath, registered result, NZCV flags, and iterative shifts.
- Sits between the decode/operand-fetch stage and register writeback.
- Accepts one operation at a time on a valid/ready input channel and returns the result on a valid/ready output channel.

Parameters:
- WIDTH, 32, datapath width in bits (minimum 4).
- SHAMT_W, 5, width of the shift-amount field taken from operand2[SHAMT_W-1:0] (must satisfy 2^SHAMT_W >= WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  4  operation select.
- operand1  in  WIDTH  first operand.
- operand2  in  WIDTH  second operand / shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}, registered with result.
- err  out  1  illegal opcode for the current result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Opcodes:
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT (~operand1).
  - 0111 LSL, 1000 LSR, 1001 ASR.
  - All other codes, including 0000, are illegal.
- Reset (async, rst_n=0): state=IDLE; result=0, flags=0, err=0, out_valid=0, busy=0, shift counter=0. in_ready=1 from the first clock edge after release. Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready at a rising edge. opcode and operands are captured; later input changes are ignored.
  - Non-shift or illegal opcode: compute and register result/flags/err -> DONE.
  - Shift opcode: load working register=operand1 and count=operand2[SHAMT_W-1:0]. If count==0 -> DONE with result=operand1, C=0. Otherwise -> SHIFT.
- SHIFT:
  - One bit position per cycle; count decrements each cycle.
  - LSL fills 0 and C=bit shifted out of MSB. LSR fills 0 and C=bit shifted out of LSB. ASR replicates the MSB and C=bit shifted out of LSB.
  - C holds the last bit shifted out.
  - When count reaches 1 -> DONE on the same edge as the final shift.
  - Counts >= WIDTH run to completion: LSL/LSR give 0, ASR gives all-sign.
- DONE:
  - out_valid=1; in_ready=0.
  - result/flags/err are held stable until out_ready=1. On that edge -> IDLE (in_ready=1 next cycle).
  - No accept is possible in the same cycle as the output handshake.
- Latency, accept edge to out_valid high:
  - Non-shift/illegal: 1 cycle.
  - Shift by n>0: n+1 cycles.
  - Shift by 0: 1 cycle.
  - Throughput: at most one operation per 2 cycles.
- Arithmetic:
  - ADD uses a WIDTH+1-bit sum; C=carry-out. V=(a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - SUB: r=a-b. C=1 when there is no borrow (a>=b unsigned). V=(a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - Logic ops and NOT: C=0, V=0. Shifts: V=0.
  - N=r[MSB] and Z=(r==0) for all legal ops.
- Illegal opcode: result=0, flags={0,1,0,0}, err=1. Latency is the same as a non-shift op. err=0 for every legal op.
- in_valid while in_ready=0 has no effect. The requester must hold its request until accepted.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid exactly 1 cycle after accept; ADD 0xFFFFFFFF + 1 -> 0, Z=1 C=1 V=0.
- SUB 5-5 -> 0, Z=1 C=1 V=0. SUB 0-1 -> 0xFFFFFFFF, N=1 C=0 V=0. SUB 0x80000000-1 -> 0x7FFFFFFF, V=1.
- Shifts, each with in_ready=0 and busy=1 throughout:
  - LSL 0x00000001 by 4 -> 0x00000010, out_valid 5 cycles after accept.
  - LSR 0x00000003 by 1 -> 0x00000001, C=1.
  - ASR 0x80000000 by 31 -> 0xFFFFFFFF, N=1 C=0.
  - LSL 0x1234 by 0 -> 0x1234 after 1 cycle.
- Backpressure:
  - Stimulus: AND 0xF0F0F0F0 & 0xFF00FF00 with out_ready=0 for 3 cycles, plus a new in_valid pulse during the stall.
  - Response: result 0xF000F000 and flags held stable, stall request ignored; in_ready=1 one cycle after out_ready handshake.
- Illegal opcode 0xF with operand1=0x55 -> result 0, err=1, flags=0100, 1-cycle latency; the next legal XOR 0xFF^0x0F returns 0xF0 with err=0.
- rst_n pulled low 2 cycles into LSL by 10 -> out_valid/result/flags/busy go 0 asynchronously, no result ever emitted; after release in_ready=1 and a fresh ADD 2+3 returns 5.
